divider_for_counter: RTL and testbench
======================================

DIVIDER_FOR_COUNTER -- requirements
Module: divider_for_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; CLK is the clock and RST_N is the reset.
REQ-002 Parameter DIVISOR, default 40000000, SHALL be the number of CLK cycles per CE_OUT pulse (1 s at 40 MHz).
REQ-003 Parameter CNT_W, default 26, SHALL be the width of the internal counter in bits.
REQ-004 Port CLK, input, 1 bit: system clock, rising-edge active, nominal 40 MHz (25 ns period).
REQ-005 Port RST_N, input, 1 bit: synchronous active-low reset, sampled on the CLK rising edge.
REQ-006 Port CE_OUT, output, 1 bit: registered clock-enable pulse for a downstream counter.

Function
REQ-007 The block SHALL hold an unsigned CNT_W-bit counter that counts 0, 1, ..., DIVISOR-1 and then wraps to 0, advancing by 1 on every CLK rising edge when RST_N=1.
REQ-008 CE_OUT SHALL be a flop output, not combinational decode, and SHALL be driven high for exactly one CLK cycle per counter period.
REQ-009 On the edge where the counter holds DIVISOR-1, the counter SHALL load 0 and CE_OUT SHALL load 1.
REQ-010 On every other non-reset edge, CE_OUT SHALL load 0.
REQ-011 The CE_OUT period SHALL be exactly DIVISOR CLK cycles, with a duty of 1/DIVISOR, and SHALL have no drift or jitter.
REQ-012 After reset release, the first CE_OUT high SHALL occur after the DIVISOR-th rising edge with RST_N=1, and SHALL last one cycle.
REQ-013 With DIVISOR=1, CE_OUT SHALL be constantly 1 from the first non-reset edge onward.
REQ-014 DIVISOR SHALL satisfy 1 <= DIVISOR <= 2^CNT_W.
REQ-015 A DIVISOR outside the range in REQ-014 SHALL cause a simulation-time $error/$fatal at elaboration.
REQ-016 The counter SHALL never hold a value >= DIVISOR; wrap SHALL use compare-and-clear, not natural binary overflow, unless DIVISOR = 2^CNT_W.
REQ-017 The block SHALL not generate derived clocks; CE_OUT is used only as an enable in the CLK domain.

Reset
REQ-018 When RST_N=0 at a rising edge, the counter SHALL load 0 and CE_OUT SHALL load 0.
REQ-019 Reset SHALL take priority over counting, including on the edge where the counter equals DIVISOR-1.
REQ-020 A reset asserted mid-period SHALL discard the partial count, and the next pulse SHALL follow the timing in REQ-012.
REQ-021 The counter and CE_OUT registers SHALL have power-up/initial value 0, so that a bench with RST_N tied high still sees defined outputs.
REQ-022 With the power-up values in REQ-021, the first CE_OUT pulse SHALL occur after DIVISOR edges.

Verification
REQ-023 DIVISOR=4, RST_N low 3 edges then high -> CE_OUT=0 during reset; CE_OUT=1 only in the cycle after the 4th, 8th and 12th post-reset edges.
REQ-024 DIVISOR=4, count 200 cycles -> exactly 50 CE_OUT pulses, each exactly 1 cycle wide, with a spacing of 4 cycles.
REQ-025 DIVISOR=5, RST_N pulsed low for 1 edge when counter=4 -> no CE_OUT pulse on that edge; the next pulse comes 5 edges after release.
REQ-026 DIVISOR=1, RST_N high -> CE_OUT=1 continuously after the first edge; RST_N low -> CE_OUT=0 on the next edge.
REQ-027 Default DIVISOR=40000000, CLK=25 ns, RST_N tied high -> CE_OUT rises at t≈1 s, then every 1.000000 s, with a width of 25 ns.
REQ-028 Every bench run SHALL include a check that CE_OUT is never high on two consecutive cycles when DIVISOR>1.

Source files
------------

// File: rtl/divider_for_counter.sv
// Divides CLK into a one-cycle clock-enable pulse every DIVISOR cycles.
// CE_OUT is registered and only ever used as an enable inside the CLK domain.
module divider_for_counter #(
  parameter int unsigned DIVISOR = 40000000,
  parameter int unsigned CNT_W   = 26
) (
  input  logic CLK,
  input  logic RST_N,
  output logic CE_OUT
);

  localparam longint unsigned CNT_RANGE = 64'(1) << CNT_W;

  generate
    if (DIVISOR == 0 || 64'(DIVISOR) > CNT_RANGE) begin : g_bad_divisor
      $error("divider_for_counter: DIVISOR=%0d outside 1..2**CNT_W (CNT_W=%0d)", DIVISOR, CNT_W);
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  // Declaration initialisers give defined outputs even with RST_N tied high.
  logic [CNT_W-1:0] cnt_q = '0;
  logic [CNT_W-1:0] cnt_d;
  logic             ce_q  = 1'b0;
  logic             ce_d;
  logic             wrap;

  // Compare-and-clear keeps the count below DIVISOR for any legal DIVISOR.
  always_comb begin
    wrap  = (cnt_q == LAST);
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    ce_d  = wrap;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign CE_OUT = ce_q;

endmodule

// File: tb/tb_divider_for_counter.sv
// Directed, table-driven bench for divider_for_counter across several DIVISOR settings.
module tb_divider_for_counter;

  logic clk = 1'b0;
  logic rst4 = 1'b0;
  logic rst5 = 1'b0;
  logic rst1 = 1'b0;
  logic ce4, cew, ce5, ce1, ced;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  divider_for_counter #(.DIVISOR(4), .CNT_W(8)) u_d4 (.CLK(clk), .RST_N(rst4), .CE_OUT(ce4));
  divider_for_counter #(.DIVISOR(4), .CNT_W(2)) u_dw (.CLK(clk), .RST_N(rst4), .CE_OUT(cew));
  divider_for_counter #(.DIVISOR(5), .CNT_W(3)) u_d5 (.CLK(clk), .RST_N(rst5), .CE_OUT(ce5));
  divider_for_counter #(.DIVISOR(1), .CNT_W(1)) u_d1 (.CLK(clk), .RST_N(rst1), .CE_OUT(ce1));
  divider_for_counter u_def (.CLK(clk), .RST_N(1'b1), .CE_OUT(ced));

  typedef struct packed {
    logic rst_n;
    logic exp_ce;
  } vec_t;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // Pulses must never be two cycles wide when DIVISOR > 1.
  logic p4 = 1'b0, pw = 1'b0, p5 = 1'b0, pd = 1'b0;
  always @(negedge clk) begin
    chk("no_double_d4", p4 & ce4, 1'b0);
    chk("no_double_dw", pw & cew, 1'b0);
    chk("no_double_d5", p5 & ce5, 1'b0);
    chk("no_double_def", pd & ced, 1'b0);
    p4 = ce4; pw = cew; p5 = ce5; pd = ced;
  end

  vec_t tbl [22];
  int   pulses;
  int   last_pulse;

  initial begin
    // 3 reset edges, 13 counting edges, one more, a mid-period reset, then 4 edges
    tbl = '{
      '{1'b0, 1'b0}, '{1'b0, 1'b0}, '{1'b0, 1'b0},
      '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b1},
      '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b1},
      '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b1},
      '{1'b1, 1'b0},
      '{1'b1, 1'b0},
      '{1'b0, 1'b0},
      '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b1}
    };

    #1;
    chk("powerup_d4", ce4, 1'b0);
    chk("powerup_def", ced, 1'b0);

    for (int i = 0; i < 22; i++) begin
      rst4 = tbl[i].rst_n;
      edge_sample();
      chk($sformatf("tbl_d4[%0d]", i), ce4, tbl[i].exp_ce);
      chk($sformatf("tbl_dw[%0d]", i), cew, tbl[i].exp_ce);
    end

    // 200 free-running cycles: 50 pulses, each 4 cycles apart
    pulses = 0;
    last_pulse = 0;
    for (int c = 1; c <= 200; c++) begin
      edge_sample();
      if (ce4) begin
        pulses++;
        chk($sformatf("spacing_d4@%0d", c), (c - last_pulse) == 4, 1'b1);
        last_pulse = c;
      end
    end
    chk("pulse_count_200", pulses == 50, 1'b1);

    // DIVISOR=5: reset on the edge where the counter holds 4
    rst5 = 1'b0;
    edge_sample();
    rst5 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      edge_sample();
      chk($sformatf("d5_pre[%0d]", k), ce5, 1'b0);
    end
    rst5 = 1'b0;
    edge_sample();
    chk("d5_reset_priority", ce5, 1'b0);
    rst5 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      edge_sample();
      chk($sformatf("d5_post[%0d]", k), ce5, (k == 5) ? 1'b1 : 1'b0);
    end
    edge_sample();
    chk("d5_width", ce5, 1'b0);

    // DIVISOR=1: constant enable, dropped by reset for one edge
    for (int k = 0; k < 2; k++) begin
      edge_sample();
      chk($sformatf("d1_reset[%0d]", k), ce1, 1'b0);
    end
    rst1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      edge_sample();
      chk($sformatf("d1_run[%0d]", k), ce1, 1'b1);
    end
    rst1 = 1'b0;
    edge_sample();
    chk("d1_reset_again", ce1, 1'b0);
    rst1 = 1'b1;
    edge_sample();
    chk("d1_resume", ce1, 1'b1);

    // Default divisor never pulses within a short window
    pulses = 0;
    for (int c = 0; c < 300; c++) begin
      edge_sample();
      if (ced) pulses++;
    end
    chk("def_no_early_pulse", pulses == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
